// File: rtl/serial_compare_ctrl_if.sv
// serial_compare_ctrl_if: start/done handshake plus the port pair to the shared 2-bit comparator slice.
interface serial_compare_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       cmp_a;
    logic [1:0]       cmp_b;
    logic [2:0]       cmp_c;
    logic             busy;
    logic             done;
    logic [2:0]       result;
    logic             err;
    modport master (output start, a, b, cmp_c, input cmp_a, cmp_b, busy, done, result, err);
    modport slave  (input start, a, b, cmp_c, output cmp_a, cmp_b, busy, done, result, err);
endinterface

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: MSB-first serial magnitude compare through one external 2-bit comparator slice.
// Optional SERIAL_CMP_EARLY_EXIT_EN: leave CMP on the first non-equal pair instead of scanning all pairs.
module serial_compare_ctrl #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    serial_compare_ctrl_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IW-1:0]    idx;
    logic [2:0]       dec, dec_n;
    logic             err_acc, err_n, one_hot, hit, last, accept;
    always_comb begin
        one_hot = (bus.cmp_c == 3'b100) || (bus.cmp_c == 3'b010) || (bus.cmp_c == 3'b001);
        hit     = one_hot && (bus.cmp_c != 3'b001) && (dec == 3'b000);
        dec_n   = hit ? bus.cmp_c : dec;
        err_n   = err_acc | ~one_hot;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        last    = (idx == '0) || hit;
`else
        last    = (idx == '0);
`endif
        accept  = bus.start && (state == IDLE || state == DONE);
        bus.cmp_a = (state == CMP) ? a_reg[{idx, 1'b0} +: 2] : 2'b00;
        bus.cmp_b = (state == CMP) ? b_reg[{idx, 1'b0} +: 2] : 2'b00;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            idx        <= '0;
            dec        <= 3'b000;
            err_acc    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= 3'b000;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                state      <= CMP;
                a_reg      <= bus.a;
                b_reg      <= bus.b;
                idx        <= IW'(N - 1);
                dec        <= 3'b000;
                err_acc    <= 1'b0;
                bus.busy   <= 1'b1;
                bus.result <= 3'b000;
                bus.err    <= 1'b0;
            end else if (state == CMP) begin
                dec     <= dec_n;
                err_acc <= err_n;
                idx     <= idx - 1'b1;
                if (last) begin
                    // error wins over any decision; no decision at all means every pair was equal
                    state      <= DONE;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.err    <= err_n;
                    bus.result <= err_n ? 3'b000 : (dec_n != 3'b000) ? dec_n : 3'b001;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequencer that compares two WIDTH-bit unsigned operands by stepping a shared 2-bit magnitude comparator slice across them, most-significant pair first. It sits beside one 2-bit comparator instance: it drives that instance's operand inputs and samples its {gt, lt, eq} result one pair per cycle. It reports the final relation through a start/done handshake. Wide compares cost one comparator slice plus a small FSM instead of a full parallel tree.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2; pair count N = WIDTH/2.
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cmp_a  output  2  A pair presented to the comparator slice.
- cmp_b  output  2  B pair presented to the comparator slice.
- cmp_c  input  3  slice result: bit2 = A>B, bit1 = A<B, bit0 = A==B.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse when result is final.
- result  output  3  final relation, same encoding as cmp_c; held until the next accepted start.
- err  output  1  valid with done; a sampled cmp_c was not one-hot.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE: start=1 latches a and b into a_reg and b_reg, sets idx=N-1, clears the pending decision and err, clears result to 000, and goes to CMP.
- CMP: cmp_a = a_reg[2*idx+1:2*idx] and cmp_b = b_reg[2*idx+1:2*idx], driven combinationally from registers. cmp_c is sampled at the end of the cycle.
  - First sampled value that is not 001 (and is one-hot) becomes the decision. Later pairs never override a recorded decision.
  - A sampled value that is not one-hot sets sticky err.
  - If idx==0 or an early-exit condition holds (see Configuration), go to DONE. Otherwise idx decrements.
- DONE: done=1 for exactly one cycle.
  - result = decision; 001 if every pair was equal; 000 if err is set.
  - start=1 in DONE is accepted the same way as in IDLE (back-to-back): go to CMP.
  - Otherwise go to IDLE.
- start while busy is ignored and not queued. a and b changing during CMP have no effect.
- Outside CMP, cmp_a and cmp_b drive 00.
- Reset values: busy 0, done 0, result 000, err 0, cmp_a 00, cmp_b 00, state IDLE. Reset asserted in any state aborts the operation at that edge, with no done pulse.

## Timing
- Accepting edge is cycle 0. CMP occupies cycles 1..k, and done is high in cycle k+1.
- Full scan: k = N. For WIDTH=8, done is high in cycle 5.
- Early exit on the j-th pair from the MSB: k = j, so done is high in cycle j+1.
- Back-to-back throughput: one compare per k+1 cycles (the DONE cycle doubles as an accept cycle).
- result and err update on the edge entering DONE and are stable from that cycle.
- Comparator slice path: register → cmp_a/cmp_b → external slice → cmp_c → FSM register. This is a single-cycle combinational path with no pipeline stage.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN defined: CMP leaves for DONE in the same cycle the first non-equal pair is sampled. Latency depends on the data.
- Not defined: all N pairs are always scanned and latency is fixed at N+1 cycles. The decision is still taken from the first non-equal pair.
- err detection is identical in both builds. In the early-exit build, pairs after the exit are not checked.

## Test plan
- WIDTH=8, a=8'hA5, b=8'hA5, start at cycle 0 → done in cycle 5, result 001, err 0 (both builds).
- a=8'h80, b=8'h7F → result 100. With the macro, done in cycle 2. Without it, done in cycle 5 and cmp_a/cmp_b step through pairs 10/01, 00/11, 00/11, 00/11.
- a=8'h12, b=8'h13 → result 010, done in cycle 5 in both builds.
- start pulsed during cycle 2 of a busy compare → ignored, with one done for the original operands. Then start held high in the DONE cycle with a=8'h00, b=8'h01 → new compare accepted with no IDLE cycle, result 010.
- rst asserted in cycle 2 of CMP → next cycle busy 0, done 0, result 000, cmp_a/cmp_b 00. A following start completes normally.
- cmp_c forced to 3'b011 on the first pair, a=b=8'h3C → done with err 1 and result 000. The next clean compare returns err 0.
